// File: rtl/dbus_mem_responder.sv
// Single-port word memory behind a simple request/ready data bus.
// Each accepted request waits WAIT_STATES cycles and then answers with a one-cycle ready strobe.
module dbus_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_we,
    input  logic        dbus_re,
    output logic [31:0] dbus_rdata,
    output logic        dbus_ready,
    output logic        dbus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LP_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_re;

    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_we;
    logic        w_re;
    logic [AW-1:0] w_idx;
    logic        w_err;
    logic        w_accept;
    logic        w_enter_resp;
    logic        w_wr_commit;

    assign w_accept = (r_state == S_IDLE) && (dbus_we || dbus_re);

    // With zero wait states the accept edge is also the RESP entry edge, so
    // the live inputs must be used; otherwise the latched request is used.
    always_comb begin
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_be    = r_be;
        w_we    = r_we;
        w_re    = r_re;
        if (r_state == S_IDLE) begin
            w_addr  = dbus_addr;
            w_wdata = dbus_wdata;
            w_be    = dbus_be;
            w_we    = dbus_we;
            w_re    = dbus_re;
        end
    end

    assign w_idx = w_addr[AW+1:2];
    assign w_err = (w_addr[1:0] != 2'b00)
                 || (w_addr[31:AW+2] != '0)
                 || (w_we && w_re)
                 || (w_we && (w_be == 4'b0000));

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (dbus_we || dbus_re) begin
                    if (WAIT_STATES == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LP_CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP);
    assign w_wr_commit  = w_enter_resp && w_we && !w_err && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_enter_resp && w_err;
            r_rdata <= (w_enter_resp && w_re && !w_err) ? r_mem[w_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= dbus_addr;
            r_wdata <= dbus_wdata;
            r_be    <= dbus_be;
            r_we    <= dbus_we;
            r_re    <= dbus_re;
        end
    end

    // Storage is deliberately not reset; rst_n only gates a pending commit.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dbus_ready = (r_state == S_RESP);
    assign dbus_rdata = r_rdata;
    assign dbus_err   = r_err;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Bench for dbus_mem_responder: one instance with one wait state (64 words) and
// one with zero wait states (16 words), checked against a word-array model.
module tb_dbus_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a0, wd0, rd0, a1, wd1, rd1;
    logic [3:0]  b0, b1;
    logic        we0, re0, we1, re1, rdy0, rdy1, e0, e1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] mm [2][64];

    always #5 clk = ~clk;

    dbus_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .dbus_addr(a0), .dbus_wdata(wd0), .dbus_be(b0),
        .dbus_we(we0), .dbus_re(re0), .dbus_rdata(rd0), .dbus_ready(rdy0), .dbus_err(e0)
    );

    dbus_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .dbus_addr(a1), .dbus_wdata(wd1), .dbus_be(b1),
        .dbus_we(we1), .dbus_re(re1), .dbus_rdata(rd1), .dbus_ready(rdy1), .dbus_err(e1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input logic w, input logic r);
        if (d == 0) begin
            a0 = a; wd0 = wd; b0 = b; we0 = w; re0 = r;
        end else begin
            a1 = a; wd1 = wd; b1 = b; we1 = w; re1 = r;
        end
    endtask

    task automatic sample(input int d, output logic rdy, output logic e, output logic [31:0] rd);
        if (d == 0) begin
            rdy = rdy0; e = e0; rd = rd0;
        end else begin
            rdy = rdy1; e = e1; rd = rd1;
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 64;
    endfunction

    // Reference: decide the error outcome from the request alone, then apply
    // the write lane by lane or fetch the word for a read.
    function automatic void model(input int d, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] b, input logic w, input logic r,
                                  output logic e, output logic [31:0] rd);
        int unsigned idx;
        idx = a >> 2;
        e   = (a % 4 != 0) || (idx >= depth_of(d)) || (w && r) || (w && b == 4'b0000);
        rd  = 32'h0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mm[d][idx[5:0]][8*i +: 8] = wd[8*i +: 8];
            end else begin
                rd = mm[d][idx[5:0]];
            end
        end
    endfunction

    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic w, input logic r, input bit scr,
                       output logic [31:0] rd_o, output logic e_o);
        logic        exp_e, rdy, e;
        logic [31:0] exp_rd, rd;
        int          lat, ws;
        ws = (d == 0) ? 0 : 1;
        model(d, a, wd, b, w, r, exp_e, exp_rd);
        @(negedge clk);
        drive(d, a, wd, b, w, r);
        lat = 0; rd_o = 32'h0; e_o = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            sample(d, rdy, e, rd);
            if (rdy) begin
                lat = c; rd_o = rd; e_o = e;
                break;
            end
            chk("wait_err_low", {31'b0, e}, 32'h0);
            chk("wait_rdata_zero", rd, 32'h0);
            if (scr && c == 1) drive(d, ~a, ~wd, ~b, r, w);
        end
        drive(d, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("latency", 32'(lat), 32'(1 + ws));
        chk("resp_err", {31'b0, e_o}, {31'b0, exp_e});
        chk("resp_rdata", rd_o, exp_rd);
        @(posedge clk); #1;
        sample(d, rdy, e, rd);
        chk("ready_one_cycle", {31'b0, rdy}, 32'h0);
        chk("rdata_after_resp", rd, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, prior;
        logic        e, rdy, w, r;
        logic [3:0]  b;
        int          hits;

        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d, rdy, e, rd);
            chk("reset_ready", {31'b0, rdy}, 32'h0);
            chk("reset_err", {31'b0, e}, 32'h0);
            chk("reset_rdata", rd, 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value so later reads are predictable.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < depth_of(d); i++)
                txn(d, 32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0, 1'b0, rd, e);

        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, rd, e);
        chk("full_write_err", {31'b0, e}, 32'h0);
        txn(1, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, rd, e);
        chk("full_read_data", rd, 32'hDEADBEEF);
        txn(1, 32'h10, 32'h000000AA, 4'b0001, 1'b1, 1'b0, 1'b0, rd, e);
        txn(1, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, rd, e);
        chk("partial_merge", rd, 32'hDEADBEAA);

        txn(1, 32'h12, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, rd, e);
        chk("misaligned_err", {31'b0, e}, 32'h1);
        txn(1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, rd, e);
        chk("oor_err", {31'b0, e}, 32'h1);
        chk("oor_rdata", rd, 32'h0);
        txn(1, 32'h10, 32'h11111111, 4'h0, 1'b1, 1'b0, 1'b0, rd, e);
        chk("be0_err", {31'b0, e}, 32'h1);
        txn(1, 32'h10, 32'h22222222, 4'hF, 1'b1, 1'b1, 1'b0, rd, e);
        chk("we_re_err", {31'b0, e}, 32'h1);
        txn(1, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, rd, e);
        chk("unchanged_after_err", rd, 32'hDEADBEAA);

        txn(1, 32'h14, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b1, rd, e);
        txn(1, 32'h14, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, rd, e);
        chk("latched_inputs", rd, 32'hCAFEF00D);

        // Abort a write while it sits in WAIT.
        prior = mm[1][8];
        @(negedge clk);
        drive(1, 32'h20, 32'h55555555, 4'hF, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        sample(1, rdy, e, rd);
        chk("async_reset_ready", {31'b0, rdy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            sample(1, rdy, e, rd);
            if (rdy) hits++;
        end
        chk("abort_no_ready", 32'(hits), 32'h0);
        txn(1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, rd, e);
        chk("abort_no_write", rd, prior);

        // Zero wait states, read held high: ready every other cycle.
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            @(posedge clk); #1;
            sample(0, rdy, e, rd);
            chk("b2b_ready_high", {31'b0, rdy}, 32'h1);
            chk("b2b_data", rd, mm[0][p % 2]);
            drive(0, (p % 2 == 0) ? 32'h4 : 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
            @(posedge clk); #1;
            sample(0, rdy, e, rd);
            chk("b2b_ready_low", {31'b0, rdy}, 32'h0);
        end
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int d, dep, k;
            d   = (n % 3 == 0) ? 0 : 1;
            dep = depth_of(d);
            k   = $urandom_range(0, 9);
            a   = 32'($urandom_range(0, dep - 1)) << 2;
            if (k == 8) a = a | 32'($urandom_range(1, 3));
            if (k == 9) a = a + 32'(dep * 4 * $urandom_range(1, 100));
            r = 1'($urandom_range(0, 1));
            w = !r;
            if ($urandom_range(0, 9) == 0) begin w = 1'b1; r = 1'b1; end
            b = 4'($urandom_range(0, 15));
            txn(d, a, $urandom, b, w, r, 1'($urandom_range(0, 1)), rd, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dbus_mem_responder.md
DBUS_MEM_RESPONDER -- requirements
Module: dbus_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, 4..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the number of wait cycles inserted between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port dbus_addr  input  32  byte address of the access.
REQ-006 SHALL have port dbus_wdata  input  32  write data; byte lane i is bits [8i+7:8i].
REQ-007 SHALL have port dbus_be  input  4  byte enables for writes; ignored for reads.
REQ-008 SHALL have port dbus_we  input  1  write request.
REQ-009 SHALL have port dbus_re  input  1  read request.
REQ-010 SHALL have port dbus_rdata  output  32  read data, valid only while dbus_ready=1.
REQ-011 SHALL have port dbus_ready  output  1  one-cycle response strobe ending the transaction.
REQ-012 SHALL have port dbus_err  output  1  error flag, valid only while dbus_ready=1.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP; it SHALL be in IDLE after reset.
REQ-014 In IDLE, when dbus_we or dbus_re is 1 at a rising edge, the block SHALL accept the request and latch addr, wdata, be, we and re; input changes after acceptance SHALL be ignored.
REQ-015 On acceptance, the FSM SHALL go to WAIT and load the wait counter with WAIT_STATES-1 if WAIT_STATES>0; if WAIT_STATES=0 it SHALL go directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-017 dbus_ready SHALL be 1 for exactly the one cycle spent in RESP; RESP SHALL always return to IDLE.
REQ-018 Latency: for a request first presented in cycle k of IDLE, dbus_ready SHALL be high in cycle k+1+WAIT_STATES.
REQ-019 Back-to-back: a request asserted in the cycle after RESP SHALL be treated as a new request; the requester SHALL drop we and re on the edge where it samples dbus_ready=1.
REQ-020 Word index SHALL be dbus_addr[31:2]; a request is in range when index < DEPTH_WORDS.
REQ-021 Error conditions: addr[1:0]!=0; index out of range; we and re both 1; or a write with be=0000. Any error condition SHALL set dbus_err=1 in RESP.
REQ-022 On an error, no storage SHALL be modified, and dbus_rdata SHALL be 32'h0.
REQ-023 A valid write SHALL update only the enabled byte lanes of the addressed word, on the edge entering RESP; dbus_rdata SHALL be 32'h0 in RESP.
REQ-024 A valid read SHALL capture the addressed word into dbus_rdata on the edge entering RESP.
REQ-025 A read following a write to the same word SHALL return the written bytes, merged with the prior unenabled bytes.
REQ-026 Outside RESP, dbus_ready, dbus_err and dbus_rdata SHALL be 0.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counter=0, dbus_ready=0, dbus_err=0 and dbus_rdata=0, independent of clk.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 A reset asserted during WAIT or RESP SHALL abort the transaction with no write committed if the abort precedes the RESP entry edge.
REQ-030 After rst_n deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-031 The bench SHALL cover: WAIT_STATES=1, write addr 0x10, wdata 0xDEADBEEF, be=1111, then a read of 0x10 -> dbus_ready in cycle k+2 of each request, rdata=0xDEADBEEF, err=0.
REQ-032 The bench SHALL cover: a partial write of 0x10, wdata 0x000000AA, be=0001, then a read -> rdata=0xDEADBEAA.
REQ-033 The bench SHALL cover: a read at 0x12, and a read at 4*DEPTH_WORDS -> ready with err=1 and rdata=0; a write with be=0000, and we=re=1 -> err=1 and memory unchanged on readback.
REQ-034 The bench SHALL cover: WAIT_STATES=0 with back-to-back reads at 0x0 and 0x4 held continuously -> ready high in alternate cycles with correct data each time.
REQ-035 The bench SHALL cover: rst_n pulsed low during WAIT of a write of 0x55555555 to 0x20 -> ready never asserts; a later read of 0x20 returns the prior contents.
REQ-036 The bench SHALL cover: inputs changed during WAIT -> the response reflects the values latched at acceptance.
